// File: rtl/forward_pkg.sv
// Shared types and defaults for the forwarding scoreboard: in-flight entry
// layout, select encoding and default parameter values.
package forward_pkg;

    localparam int unsigned DEF_REG_AW    = 4;
    localparam int unsigned DEF_NUM_SRC   = 2;
    localparam int unsigned DEF_DEPTH     = 3;
    localparam int unsigned DEF_NOFWD_REG = 15;

    // Entries store register indices at this fixed width; REG_AW must not exceed it.
    localparam int unsigned MAX_REG_AW    = 8;

    localparam int unsigned SEL_REGFILE   = 0;

    typedef struct packed {
        logic                  vld;
        logic [MAX_REG_AW-1:0] dest;
        logic                  is_load;
    } entry_t;

    localparam entry_t ENTRY_EMPTY = '0;

endpackage

// File: rtl/fwd_prio_enc.sv
// Nearest-stage priority encoder for one source operand: match[k-1] flags
// stage k, output is the smallest flagged stage or SEL_REGFILE.
module fwd_prio_enc
    import forward_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned SW    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0] match,
    output logic [SW-1:0]    sel
);

    // Walk from the oldest stage down so the youngest match is written last.
    always_comb begin
        sel = SW'(SEL_REGFILE);
        for (int unsigned k = DEPTH; k > 0; k--) begin
            if (match[k-1]) sel = SW'(k);
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Register-hazard scoreboard: tracks destinations of in-flight instructions,
// picks forwarding sources and requests load-use / stall-only stalls.
// Optional hazard counters are built when FORWARD_SCOREBOARD_STATS_EN is defined.
module forward_scoreboard
    import forward_pkg::*;
#(
    parameter int unsigned REG_AW    = DEF_REG_AW,
    parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned NOFWD_REG = DEF_NOFWD_REG
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]              id_src,
    input  logic [NUM_SRC-1:0]                     id_src_used,
    input  logic                                   id_wb_en,
    input  logic                                   id_is_load,
    input  logic [REG_AW-1:0]                      id_dest,
    input  logic                                   fwd_en,
    input  logic                                   hold,
    input  logic                                   flush,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]     sel_src,
    output logic                                   stall
`ifdef FORWARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                            fwd_cnt,
    output logic [31:0]                            stall_cnt
`endif
);

    localparam int unsigned SW = $clog2(DEPTH + 1);
    localparam logic [MAX_REG_AW-1:0] NOFWD_EXT = MAX_REG_AW'(NOFWD_REG);

    entry_t            ent [1:DEPTH];
    entry_t            new_ent;
    logic [DEPTH-1:0]  match   [NUM_SRC];
    logic [SW-1:0]     enc_sel [NUM_SRC];
    logic              load_use;
    logic              any_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 1; k <= DEPTH; k++) ent[k] <= ENTRY_EMPTY;
        end else if (!hold) begin
            for (int unsigned k = 2; k <= DEPTH; k++) ent[k] <= ent[k-1];
            ent[1] <= new_ent;
        end
    end

    always_comb begin
        new_ent = ENTRY_EMPTY;
        if (id_valid && !stall && !flush) begin
            new_ent.vld     = id_wb_en;
            new_ent.dest    = MAX_REG_AW'(id_dest);
            new_ent.is_load = id_is_load;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            match[i] = '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                match[i][k-1] = id_src_used[i] && ent[k].vld
                             && (ent[k].dest != NOFWD_EXT)
                             && (ent[k].dest == MAX_REG_AW'(id_src[i*REG_AW +: REG_AW]));
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_enc
        fwd_prio_enc #(
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_enc (
            .match (match[g]),
            .sel   (enc_sel[g])
        );
    end

    always_comb begin
        sel_src = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sel_src[i*SW +: SW] = fwd_en ? enc_sel[i] : SW'(SEL_REGFILE);
        end
    end

    // Stall looks only at entries and ID inputs, never at its own value.
    always_comb begin
        load_use  = 1'b0;
        any_match = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            load_use  = load_use  | (match[i][0] & ent[1].is_load);
            any_match = any_match | (|match[i]);
        end
        stall = id_valid && !flush && (fwd_en ? load_use : any_match);
    end

`ifdef FORWARD_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            if ((|sel_src) && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 32'd1;
            if (stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed scoreboard bench for forward_scoreboard (default build, no stats ports).
module tb_forward_scoreboard;

    localparam int unsigned REG_AW  = 4;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned DEPTH   = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      id_wb_en;
    logic                      id_is_load;
    logic [REG_AW-1:0]         id_dest;
    logic                      fwd_en;
    logic                      hold;
    logic                      flush;
    logic [3:0]                sel_src;
    logic                      stall;

    int checks   = 0;
    int failures = 0;

    string      tag_q   [$];
    logic [3:0] sel_q   [$];
    logic       stall_q [$];

    always #5 clk = ~clk;

    forward_scoreboard #(
        .REG_AW    (REG_AW),
        .NUM_SRC   (NUM_SRC),
        .DEPTH     (DEPTH),
        .NOFWD_REG (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_wb_en    (id_wb_en),
        .id_is_load  (id_is_load),
        .id_dest     (id_dest),
        .fwd_en      (fwd_en),
        .hold        (hold),
        .flush       (flush),
        .sel_src     (sel_src),
        .stall       (stall)
    );

    task automatic issue(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] used, input logic wb, input logic ld,
                         input logic [3:0] d);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_wb_en    = wb;
        id_is_load  = ld;
        id_dest     = d;
    endtask

    task automatic idle();
        issue(1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] exp_sel, input logic exp_stall);
        string      t;
        logic [3:0] es;
        logic       est;
        tag_q.push_back(tag);
        sel_q.push_back(exp_sel);
        stall_q.push_back(exp_stall);
        #1;
        t   = tag_q.pop_front();
        es  = sel_q.pop_front();
        est = stall_q.pop_front();
        checks++;
        assert (sel_src === es) else begin
            failures++;
            $error("FAIL %s sel_src observed=%b expected=%b", t, sel_src, es);
        end
        checks++;
        assert (stall === est) else begin
            failures++;
            $error("FAIL %s stall observed=%b expected=%b", t, stall, est);
        end
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; flush = 1'b0; fwd_en = 1'b1;
        issue(1'b1, 4'd1, 4'd0, 2'b01, 1'b1, 1'b0, 4'd2);
        step("reset_state", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        tick();

        // ADD r1 ; ADD r2,r1
        issue(1'b1, 4'd8, 4'd9, 2'b11, 1'b1, 1'b0, 4'd1);
        step("add_r1", 4'b0000, 1'b0);
        tick();
        issue(1'b1, 4'd1, 4'd9, 2'b11, 1'b1, 1'b0, 4'd2);
        step("add_use_r1", 4'b0001, 1'b0);
        tick();
        idle(); tick(); tick(); tick();

        // LDR r3 ; ADD r4,r3
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, 4'd3);
        step("ldr_r3", 4'b0000, 1'b0);
        tick();
        issue(1'b1, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 4'd4);
        step("load_use_stall", 4'b0001, 1'b1);
        flush = 1'b1;
        step("load_use_flush", 4'b0001, 1'b0);
        flush = 1'b0;
        id_valid = 1'b0;
        step("load_use_novalid", 4'b0001, 1'b0);
        id_valid = 1'b1;
        tick();
        step("load_use_resolved", 4'b0010, 1'b0);
        tick();
        idle(); tick(); tick(); tick();

        // r5 in stages 1 and 3, r7 between
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd5); tick();
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd7); tick();
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd5); tick();
        issue(1'b1, 4'd5, 4'd5, 2'b10, 1'b1, 1'b0, 4'd8);
        step("nearest_wins", 4'b0100, 1'b0);
        id_valid = 1'b0;
        tick();
        step("r5_stage2", 4'b1000, 1'b0);
        tick();
        step("r5_stage3", 4'b1100, 1'b0);
        idle(); tick(); tick(); tick();

        // stall-only mode: r6 walks through all stages
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd6); tick();
        fwd_en = 1'b0;
        issue(1'b1, 4'd6, 4'd0, 2'b01, 1'b0, 1'b0, 4'd10);
        step("nofwd_stall_s1", 4'b0000, 1'b1);
        tick();
        step("nofwd_stall_s2", 4'b0000, 1'b1);
        tick();
        step("nofwd_stall_s3", 4'b0000, 1'b1);
        tick();
        step("nofwd_released", 4'b0000, 1'b0);
        tick();
        fwd_en = 1'b1;
        issue(1'b1, 4'd10, 4'd0, 2'b01, 1'b1, 1'b0, 4'd12);
        step("no_wb_no_match", 4'b0000, 1'b0);
        idle(); tick(); tick(); tick();

        // r15 never forwarded; hold freezes entries
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd15); tick();
        issue(1'b1, 4'd15, 4'd0, 2'b01, 1'b1, 1'b0, 4'd1);
        step("pc_never_fwd", 4'b0000, 1'b0);
        tick();
        hold = 1'b1;
        issue(1'b1, 4'd1, 4'd0, 2'b01, 1'b1, 1'b0, 4'd2);
        step("hold_before", 4'b0001, 1'b0);
        tick();
        step("hold_cycle1", 4'b0001, 1'b0);
        tick();
        step("hold_cycle2", 4'b0001, 1'b0);
        hold = 1'b0;
        tick();
        issue(1'b1, 4'd1, 4'd2, 2'b11, 1'b1, 1'b0, 4'd3);
        step("hold_released", 4'b0110, 1'b0);
        flush = 1'b1;
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd11);
        tick();
        flush = 1'b0;
        issue(1'b1, 4'd11, 4'd0, 2'b01, 1'b1, 1'b0, 4'd3);
        step("flush_squash", 4'b0000, 1'b0);
        idle(); tick(); tick(); tick();

        // reset with three valid entries in flight
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd1); tick();
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd2); tick();
        issue(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, 4'd3); tick();
        issue(1'b1, 4'd3, 4'd1, 2'b11, 1'b1, 1'b0, 4'd4);
        step("pre_reset", 4'b1101, 1'b1);
        rst = 1'b0;
        step("reset_async", 4'b0000, 1'b0);
        tick();
        step("reset_held", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step("post_reset_first", 4'b0000, 1'b0);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 4: register-index width.
REQ-002 SHALL have parameter NUM_SRC, default 2: source operands checked per instruction.
REQ-003 SHALL have parameter DEPTH, default 3: tracked in-flight stages (1=EXE, 2=MEM, 3=WB).
REQ-004 SHALL have parameter NOFWD_REG, default 15: register index never forwarded (PC).
REQ-005 SHALL have ports clk, input, 1: the one clock; all state on rising edge.
REQ-006 SHALL have ports rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have id_valid, input, 1: ID stage holds a real instruction.
REQ-008 SHALL have id_src, input, NUM_SRC*REG_AW: source register indices, src0 in LSBs.
REQ-009 SHALL have id_src_used, input, NUM_SRC: per-source "operand read" flag.
REQ-010 SHALL have id_wb_en, id_is_load, input, 1 each; id_dest, input, REG_AW.
REQ-011 SHALL have fwd_en, input, 1: forwarding enabled (0 = stall-only mode).
REQ-012 SHALL have hold, input, 1: whole pipeline frozen this cycle.
REQ-013 SHALL have flush, input, 1: squash the ID instruction.
REQ-014 SHALL have sel_src, output, NUM_SRC*SW, SW=$clog2(DEPTH+1): per-source select, 0=regfile, k=stage k.
REQ-015 SHALL have stall, output, 1: hazard stall request to ID/IF.

Function
REQ-016 SHALL hold DEPTH entries {vld, dest, is_load}; entry k = instruction in stage k.
REQ-017 SHALL, on hold=0, shift entry k-1 into k and load entry 1 with the ID instruction, or a bubble (vld=0) when id_valid=0, stall=1 or flush=1.
REQ-018 SHALL, on hold=1, keep all entries; flush is ignored during hold (upstream keeps it asserted).
REQ-019 SHALL set vld of a loaded entry only when id_wb_en=1; entry dest equal to NOFWD_REG SHALL never match.
REQ-020 SHALL compute a match for source i at stage k when id_src_used[i], entry k vld, and dest equal.
REQ-021 SHALL, with fwd_en=1, drive sel_src[i] = smallest matching k (nearest stage wins), else 0; combinational from entries and inputs.
REQ-022 SHALL, with fwd_en=1, assert stall when any source matches entry 1 with is_load=1 (load-use).
REQ-023 SHALL, with fwd_en=0, drive every sel_src to 0 and assert stall on any match in any stage.
REQ-024 SHALL gate stall with id_valid and deassert it when flush=1.
REQ-025 SHALL let stall depend on entries only, so a load-use stall lasts exactly one cycle with forwarding.

Reset
REQ-026 SHALL, with rst low, asynchronously clear all entries (vld=0, dest=0, is_load=0); sel_src=0, stall=0 follow.
REQ-027 SHALL, on reset mid-operation, discard all in-flight entries; first post-reset ID instruction sees no hazards.

Configuration
REQ-028 SHALL compile hazard statistics only when FORWARD_SCOREBOARD_STATS_EN is defined.
REQ-029 SHALL, with the macro, add outputs fwd_cnt and stall_cnt (32 bits, reset 0, saturating at all-ones), counting cycles with any nonzero sel_src / stall=1 and hold=0.
REQ-030 SHALL, without the macro, have neither port nor counter logic.

Structure
REQ-031 SHALL place the entry struct typedef, select-encoding constants (SEL_REGFILE=0) and default parameter values in package forward_pkg.
REQ-032 SHALL use one sub-module, fwd_prio_enc, the per-source nearest-stage priority encoder, instantiated NUM_SRC times.

Verification
REQ-033 SHALL cover: ADD r1 then ADD r2,r1 (fwd_en=1) -> sel_src0=1, stall=0.
REQ-034 SHALL cover: LDR r3 then ADD r4,r3 -> stall=1 one cycle, then sel_src0=2, stall=0.
REQ-035 SHALL cover: writes to r5 in stages 1 and 3, src1=r5 -> sel_src1=1 (nearest wins).
REQ-036 SHALL cover: fwd_en=0, r6 in stage 3, src0=r6 -> stall=1 until entry leaves, sel_src=0.
REQ-037 SHALL cover: dest=r15 in stage 1, src0=r15 -> sel_src0=0, stall=0; hold=1 two cycles -> entries unchanged.
REQ-038 SHALL cover: rst low mid-stream with three valid entries -> all entries cleared immediately, stall=0.
